// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [63:0] PC_RESET = 64'h0;
  localparam logic [63:0] PC_STEP  = 64'd4;
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;
  localparam int CNT_W  = 32;

  // One action is chosen per clock edge, in priority order reset > redirect > stall > advance.
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_RESET    = 2'd3
  } fetch_act_e;

endpackage

// File: rtl/if_stage_hazard_detect.sv
// Load-use hazard: the instruction in IF/ID reads a register that a load in ID/EX is writing.
module hazard_detect
  import if_stage_pkg::*;
(
  input  logic        if_id_valid,
  input  logic [31:0] if_id_instr,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  output logic        hazard
);

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       unused_instr_bits;

  assign rs1 = if_id_instr[RS1_HI:RS1_LO];
  assign rs2 = if_id_instr[RS2_HI:RS2_LO];
  assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:0]};

  // x0 never carries a dependency, so a load targeting it cannot stall.
  assign hazard = if_id_valid && id_ex_memread && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == rs1) || (id_ex_rd == rs2));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, load-use stall and branch redirect.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  output logic [63:0] imem_addr,
  output logic [63:0] if_id_pc_out,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        id_ex_flush,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [63:0] pc;
  logic        hazard;
  fetch_act_e  act;
  logic        unused_target_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard_detect (
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .hazard        (hazard)
  );

  assign imem_addr          = pc;
  assign id_ex_flush        = branch_taken | hazard;
  assign unused_target_bits = ^branch_target[1:0];

  always_comb begin
    act = ACT_ADVANCE;
    if (reset)             act = ACT_RESET;
    else if (branch_taken) act = ACT_REDIRECT;
    else if (hazard)       act = ACT_STALL;
  end

  // IF -> IF/ID boundary
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        pc           <= PC_RESET;
        if_id_pc_out <= '0;
        if_id_instr  <= '0;
        if_id_valid  <= 1'b0;
        stall_count  <= '0;
        flush_count  <= '0;
      end
      ACT_REDIRECT: begin
        pc           <= {branch_target[63:2], 2'b00};
        if_id_pc_out <= '0;
        if_id_instr  <= '0;
        if_id_valid  <= 1'b0;
        flush_count  <= sat_inc(flush_count);
      end
      ACT_STALL: begin
        stall_count  <= sat_inc(stall_count);
      end
      default: begin
        pc           <= pc + PC_STEP;
        if_id_pc_out <= pc;
        if_id_instr  <= imem_rdata;
        if_id_valid  <= 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference model predicts each edge's result.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic [63:0] imem_addr;
  logic [63:0] if_id_pc_out;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        id_ex_flush;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] pcout;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [63:0] m_pc, m_pcout;
  logic [31:0] m_instr, m_sc, m_fc;
  logic        m_valid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .imem_addr     (imem_addr),
    .if_id_pc_out  (if_id_pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .id_ex_flush   (id_ex_flush),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Drive one cycle of stimulus, check the combinational flush, push the predicted
  // post-edge state, then pop and compare it after the edge.
  task automatic step(input logic rst, input logic [31:0] rdata, input logic bt,
                      input logic [63:0] tgt, input logic mr, input logic [4:0] rd,
                      input logic chk_flush);
    logic m_haz;
    exp_t e, got;
    @(negedge clk);
    reset = rst; imem_rdata = rdata; branch_taken = bt;
    branch_target = tgt; id_ex_memread = mr; id_ex_rd = rd;
    #1;
    m_haz = m_valid && mr && (rd != 5'd0) &&
            ((rd == m_instr[19:15]) || (rd == m_instr[24:20]));
    if (chk_flush) chk("id_ex_flush", {63'd0, id_ex_flush}, {63'd0, bt | m_haz});
    if (rst) begin
      m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    end else if (bt) begin
      m_pc = {tgt[63:2], 2'b00}; m_pcout = 0; m_instr = 0; m_valid = 0; m_fc = sat32(m_fc);
    end else if (m_haz) begin
      m_sc = sat32(m_sc);
    end else begin
      m_pcout = m_pc; m_pc = m_pc + 64'd4; m_instr = rdata; m_valid = 1'b1;
    end
    e.pc = m_pc; e.pcout = m_pcout; e.instr = m_instr;
    e.valid = m_valid; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk("imem_addr",    imem_addr, got.pc);
      chk("if_id_pc_out", if_id_pc_out, got.pcout);
      chk("if_id_instr",  {32'd0, if_id_instr}, {32'd0, got.instr});
      chk("if_id_valid",  {63'd0, if_id_valid}, {63'd0, got.valid});
      chk("stall_count",  {32'd0, stall_count}, {32'd0, got.sc});
      chk("flush_count",  {32'd0, flush_count}, {32'd0, got.fc});
    end
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0020_8033;

  initial begin
    m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    reset = 1; imem_rdata = 0; branch_taken = 0; branch_target = 0;
    id_ex_memread = 0; id_ex_rd = 0;

    // reset, then three straight-line fetches
    step(1, NOP, 0, 64'd0, 0, 5'd0, 1'b0);
    step(1, NOP, 0, 64'd0, 0, 5'd0, 1'b1);
    chk("reset_pc_literal", imem_addr, 64'h0);
    step(0, NOP, 0, 64'd0, 0, 5'd0, 1'b1);
    step(0, NOP, 0, 64'd0, 0, 5'd0, 1'b1);
    step(0, NOP, 0, 64'd0, 0, 5'd0, 1'b1);
    chk("seq_pc_C",    imem_addr, 64'hC);
    chk("seq_pcout_8", if_id_pc_out, 64'h8);

    // load-use stall on rs2, then rd=x0 must not stall
    step(0, ADD, 0, 64'd0, 0, 5'd0, 1'b1);
    step(0, ADD, 0, 64'd0, 1, 5'd2, 1'b1);
    chk("stall_pc_held", imem_addr, 64'h10);
    chk("stall_cnt_1",   {32'd0, stall_count}, 64'd1);
    step(0, ADD, 0, 64'd0, 1, 5'd0, 1'b1);
    chk("x0_advanced",   imem_addr, 64'h14);

    // branch wins over an active hazard on rs1
    step(0, ADD, 1, 64'h102, 1, 5'd1, 1'b1);
    chk("br_pc_100",     imem_addr, 64'h100);
    chk("br_stall_kept", {32'd0, stall_count}, 64'd1);

    // PC wraps modulo 2^64
    step(0, NOP, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 5'd0, 1'b1);
    step(0, NOP, 0, 64'd0, 0, 5'd0, 1'b1);
    chk("wrap_pc_0", imem_addr, 64'h0);

    // reset overrides a simultaneous redirect while a hazard is pending
    step(0, ADD, 0, 64'd0, 0, 5'd0, 1'b1);
    step(1, ADD, 1, 64'h200, 1, 5'd2, 1'b1);
    chk("rst_br_pc", imem_addr, 64'h0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] rdat;
      rdat = $urandom;
      rdat[19:15] = 5'($urandom_range(0, 3));
      rdat[24:20] = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 29) == 0), rdat, ($urandom_range(0, 5) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
